// File: rtl/sys_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_timer_pkg
// Purpose  : Register offsets, control/mode bit positions and prescaler
//            reload constants shared by the sys_timer block.
// Revision : 1.0 - initial release
// ============================================================================
package sys_timer_pkg;

    // Global register offsets
    localparam logic [4:0] c_ADDR_CTRL    = 5'h00;
    localparam logic [4:0] c_ADDR_STATUS  = 5'h01;
    localparam logic [4:0] c_ADDR_MASK    = 5'h02;
    localparam logic [4:0] c_ADDR_CH_BASE = 5'h04;

    // Per-channel register offsets inside a 4-byte channel window
    localparam logic [1:0] c_OFF_CNT_LO = 2'd0;
    localparam logic [1:0] c_OFF_CNT_HI = 2'd1;
    localparam logic [1:0] c_OFF_MODE   = 2'd2;

    // CTRL and MODE bit positions
    localparam int c_CTRL_IRQ_EN      = 0;
    localparam int c_CTRL_PRESC_LONG  = 1;
    localparam int c_MODE_RUN         = 0;
    localparam int c_MODE_AUTO_RELOAD = 1;

    // Prescaler reload values (short and long period)
    localparam logic [15:0] c_PRESC_SHORT = 16'h00FF;
    localparam logic [15:0] c_PRESC_LONG  = 16'h3FFF;

    // Absolute address of register 'off' in channel 'n'
    function automatic logic [4:0] ch_reg_addr(input int n, input logic [1:0] off);
        return 5'(int'(c_ADDR_CH_BASE) + 4 * n + int'(off));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_timer_ch.sv
`default_nettype none
// ============================================================================
// Module   : sys_timer_ch
// Purpose  : One down-counter channel: reload register, run/auto-reload mode
//            and expiry detection, advanced by the shared prescaler tick.
//            Optional macro SYS_TIMER_LEGACY_ZERO_EN: committing a zero
//            reload raises an immediate expiry instead of staying silent.
// Revision : 1.0 - initial release
// ============================================================================
module sys_timer_ch
    import sys_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_wr_lo,
    input  logic       i_wr_hi,
    input  logic       i_wr_mode,
    input  logic [7:0] i_din,
    output logic [7:0] o_lo_byte,
    output logic [7:0] o_hi_byte,
    output logic [1:0] o_mode,
    output logic       o_expire
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reload;
    logic             r_run;
    logic             r_auto;

    logic             w_commit;
    logic [CNT_W-1:0] w_commit_val;
    logic             w_dec;
    logic             w_last;

    // Width-dependent commit point: 8-bit channels load on the LO byte,
    // 16-bit channels wait for the HI byte and use the stored LO byte.
    if (CNT_W == 16) begin : g_w16
        assign w_commit     = i_wr_hi;
        assign w_commit_val = {i_din, r_reload[7:0]};
        assign o_hi_byte    = r_count[15:8];
    end else begin : g_w8
        logic w_unused_hi;
        assign w_unused_hi  = i_wr_hi;
        assign w_commit     = i_wr_lo;
        assign w_commit_val = i_din;
        assign o_hi_byte    = 8'h00;
    end

    assign w_dec     = i_tick & r_run & (r_count != '0);
    assign w_last    = (r_count == CNT_W'(1));
    assign o_lo_byte = r_count[7:0];
    assign o_mode    = {r_auto, r_run};

`ifdef SYS_TIMER_LEGACY_ZERO_EN
    assign o_expire = (w_dec & w_last & ~w_commit) | (w_commit & (w_commit_val == '0));
`else
    assign o_expire = w_dec & w_last & ~w_commit;
`endif

    // Counter, reload and mode state; a commit overrides a coincident tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_reload <= '0;
            r_run    <= 1'b0;
            r_auto   <= 1'b0;
        end else begin
            if (i_wr_mode) begin
                r_run  <= i_din[c_MODE_RUN];
                r_auto <= i_din[c_MODE_AUTO_RELOAD];
            end
            if (w_commit) begin
                r_reload <= w_commit_val;
                r_count  <= w_commit_val;
                r_run    <= (w_commit_val != '0);
            end else begin
                if (i_wr_lo) begin
                    r_reload[7:0] <= i_din;
                end
                if (w_dec) begin
                    if (w_last) begin
                        if (r_auto) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= '0;
                            r_run   <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_timer.sv
`default_nettype none
// ============================================================================
// Module   : sys_timer
// Purpose  : Multi-channel system timer with shared prescaler, pending /
//            mask registers, level interrupt and byte-wide register port.
//            Optional macro SYS_TIMER_LEGACY_ZERO_EN (see sys_timer_ch).
// Revision : 1.0 - initial release
// ============================================================================
module sys_timer
    import sys_timer_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       cs,
    input  logic       we,
    input  logic [4:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    logic               r_irq_en;
    logic               r_presc_long;
    logic [NUM_CH-1:0]  r_pending;
    logic [NUM_CH-1:0]  r_mask;
    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_dout;
    logic               r_irq;

    logic               w_wr;
    logic               w_tick;
    logic [PRESC_W-1:0] w_presc_reload;
    logic [NUM_CH-1:0]  w_expire;
    logic [NUM_CH-1:0]  w_clr;
    logic [7:0]         w_lo_byte [NUM_CH];
    logic [7:0]         w_hi_byte [NUM_CH];
    logic [1:0]         w_mode    [NUM_CH];
    logic [7:0]         w_rdata;

    assign w_wr           = cs & we;
    assign w_tick         = ce & (r_presc == '0);
    assign w_presc_reload = r_presc_long ? PRESC_W'(c_PRESC_LONG) : PRESC_W'(c_PRESC_SHORT);
    assign w_clr          = (w_wr && addr == c_ADDR_STATUS) ? din[NUM_CH-1:0] : '0;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        sys_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (reset),
            .i_tick    (w_tick),
            .i_wr_lo   (w_wr && addr == ch_reg_addr(n, c_OFF_CNT_LO)),
            .i_wr_hi   (w_wr && addr == ch_reg_addr(n, c_OFF_CNT_HI)),
            .i_wr_mode (w_wr && addr == ch_reg_addr(n, c_OFF_MODE)),
            .i_din     (din),
            .o_lo_byte (w_lo_byte[n]),
            .o_hi_byte (w_hi_byte[n]),
            .o_mode    (w_mode[n]),
            .o_expire  (w_expire[n])
        );
    end

    // Shared prescaler: counts down on ce, ticks and reloads at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (ce) begin
            r_presc <= w_tick ? w_presc_reload : r_presc - 1'b1;
        end
    end

    // CTRL/MASK registers and pending bits; a new expiry beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en     <= 1'b0;
            r_presc_long <= 1'b0;
            r_mask       <= '0;
            r_pending    <= '0;
        end else begin
            if (w_wr && addr == c_ADDR_CTRL) begin
                r_irq_en     <= din[c_CTRL_IRQ_EN];
                r_presc_long <= din[c_CTRL_PRESC_LONG];
            end
            if (w_wr && addr == c_ADDR_MASK) begin
                r_mask <= din[NUM_CH-1:0];
            end
            r_pending <= (r_pending & ~w_clr) | w_expire;
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & (|(r_pending & r_mask));
        end
    end

    // Read-data mux; anything not decoded reads as 0xFF
    always_comb begin
        w_rdata = 8'hFF;
        case (addr)
            c_ADDR_CTRL:   w_rdata = {6'b0, r_presc_long, r_irq_en};
            c_ADDR_STATUS: w_rdata = 8'(r_pending);
            c_ADDR_MASK:   w_rdata = 8'(r_mask);
            default:       w_rdata = 8'hFF;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (addr == ch_reg_addr(n, c_OFF_CNT_LO)) w_rdata = w_lo_byte[n];
            if (addr == ch_reg_addr(n, c_OFF_CNT_HI)) w_rdata = w_hi_byte[n];
            if (addr == ch_reg_addr(n, c_OFF_MODE))   w_rdata = {6'b0, w_mode[n]};
        end
    end

    // Read data register: captures on a read, otherwise holds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= 8'h00;
        end else if (cs && !we) begin
            r_dout <= w_rdata;
        end
    end

    assign dout = r_dout;
    assign irq  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sys_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_timer
// Purpose  : Directed self-checking bench for sys_timer (8-bit and 16-bit
//            counter builds driven from a shared register bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       cs;
    logic       we;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout8;
    logic [7:0] dout16;
    logic       irq8;
    logic       irq16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sys_timer u_dut8 (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout8),
        .irq   (irq8)
    );

    sys_timer #(.CNT_W(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout16),
        .irq   (irq16)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        cyc(1);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        cs = 1'b1; we = 1'b0; addr = a;
        cyc(1);
        cs = 1'b0;
    endtask

    task automatic do_reset();
        ce = 1'b0;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        cs = 1'b0; we = 1'b0; addr = 5'h00; din = 8'h00; ce = 1'b0; reset = 1'b0;
        cyc(2);

        // Reset state
        do_reset();
        check("rst_dout", dout8, 8'h00);
        check("rst_irq", {7'b0, irq8}, 8'h00);
        rd(5'h00); check("rst_ctrl", dout8, 8'h00);
        rd(5'h02); check("rst_mask", dout8, 8'h00);
        rd(5'h01); check("rst_status", dout8, 8'h00);

        // One-shot CH0 = 3 with short prescaler; commit coincides with a tick
        do_reset();
        wr(5'h00, 8'h01);
        wr(5'h02, 8'h01);
        rd(5'h00); check("t1_ctrl_rb", dout8, 8'h01);
        rd(5'h02); check("t1_mask_rb", dout8, 8'h01);
        ce = 1'b1;
        wr(5'h04, 8'h03);
        cyc(767);
        check("t1_irq_767", {7'b0, irq8}, 8'h00);
        cyc(1);
        check("t1_irq_768", {7'b0, irq8}, 8'h00);
        cyc(1);
        check("t1_irq_769", {7'b0, irq8}, 8'h01);
        rd(5'h04); check("t1_cnt_zero", dout8, 8'h00);
        rd(5'h06); check("t1_mode_stopped", dout8, 8'h00);
        rd(5'h01); check("t1_status", dout8, 8'h01);
        cyc(3);
        check("t1_dout_hold", dout8, 8'h01);
        cyc(300);
        rd(5'h04); check("t1_no_wrap", dout8, 8'h00);
        rd(5'h03); check("t1_undef_03", dout8, 8'hFF);
        rd(5'h0C); check("t1_undef_0c", dout8, 8'hFF);

        // CH1 auto-reload = 2: expiry every 512 ce cycles
        do_reset();
        wr(5'h0A, 8'h03);
        ce = 1'b1;
        wr(5'h08, 8'h02);
        cyc(511);
        rd(5'h01); check("t2_status_e512", dout8, 8'h00);
        rd(5'h01); check("t2_status_e513", dout8, 8'h02);
        rd(5'h08); check("t2_reloaded", dout8, 8'h02);
        wr(5'h01, 8'h02);
        cyc(508);
        rd(5'h01); check("t2_cleared", dout8, 8'h00);
        rd(5'h01); check("t2_status_again", dout8, 8'h02);

        // Clear coinciding with a new expiry on CH0
        do_reset();
        wr(5'h00, 8'h01);
        wr(5'h02, 8'h01);
        wr(5'h06, 8'h03);
        ce = 1'b1;
        wr(5'h04, 8'h01);
        cyc(511);
        check("t3_irq_before", {7'b0, irq8}, 8'h01);
        wr(5'h01, 8'h01);
        check("t3_irq_at_clr", {7'b0, irq8}, 8'h01);
        cyc(1);
        check("t3_irq_after", {7'b0, irq8}, 8'h01);
        rd(5'h01); check("t3_pending_kept", dout8, 8'h01);

        // Zero reload commit
        do_reset();
        wr(5'h04, 8'h00);
        rd(5'h01);
`ifdef SYS_TIMER_LEGACY_ZERO_EN
        check("t4_zero_pending", dout8, 8'h01);
`else
        check("t4_zero_pending", dout8, 8'h00);
`endif
        rd(5'h06); check("t4_zero_run", dout8, 8'h00);

        // 16-bit counter commit on HI write; 8-bit commits on LO
        do_reset();
        wr(5'h04, 8'h34);
        rd(5'h04);
        check("t5_w16_no_load", dout16, 8'h00);
        check("t5_w8_lo_load", dout8, 8'h34);
        rd(5'h06);
        check("t5_w16_not_run", dout16, 8'h00);
        check("t5_w8_run", dout8, 8'h01);
        wr(5'h05, 8'h12);
        rd(5'h04); check("t5_w16_lo", dout16, 8'h34);
        rd(5'h05);
        check("t5_w16_hi", dout16, 8'h12);
        check("t5_w8_hi", dout8, 8'h00);
        rd(5'h06); check("t5_w16_run", dout16, 8'h01);

        // Reset mid-count with pending set
        do_reset();
        wr(5'h00, 8'h01);
        wr(5'h02, 8'h02);
        ce = 1'b1;
        wr(5'h08, 8'h01);
        cyc(256);
        ce = 1'b0;
        cyc(1);
        check("t6_irq_set", {7'b0, irq8}, 8'h01);
        wr(5'h04, 8'h05);
        rd(5'h01); check("t6_pending", dout8, 8'h02);
        rd(5'h04); check("t6_count5", dout8, 8'h05);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t6_rst_dout", dout8, 8'h00);
        check("t6_rst_irq", {7'b0, irq8}, 8'h00);
        rd(5'h04); check("t6_rst_count", dout8, 8'h00);
        rd(5'h01); check("t6_rst_pending", dout8, 8'h00);
        rd(5'h06); check("t6_rst_mode", dout8, 8'h00);
        rd(5'h00); check("t6_rst_ctrl", dout8, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
